freq_div_ctrl: RTL and testbench

Run/stop and configuration controller for the team's programmable frequency divider datapath. Owns the divide counter and the divisor register. Accepts divisor updates over a valid/ready handshake and applies them only at a period boundary, so clock_out never shows a truncated or glitched period. Emits a one-cycle tick at each period start, which downstream logic uses as a clock enable.

---
 rtl/freq_div_ctrl.sv | 132 +++++++++++++
 tb/tb_freq_div_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl: run/stop and divisor controller for the programmable
// frequency divider. Owns the divide counter and the active divisor.
// Optional feature macro: FREQ_DIV_CTRL_PERIOD_CNT_EN adds period_count.
//
// Handshake: an update transfers on a rising clock_in edge where
// div_valid && div_ready. div_ready is simply !busy, so it is a registered
// signal. While div_ready is low the requester must hold div_valid and
// div_value stable; the request is not sampled until div_ready returns high.
module freq_div_ctrl #(
  parameter int CNT_W       = 10,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             run,
  input  logic             div_valid,
  input  logic [CNT_W-1:0] div_value,
  output logic             div_ready,
  output logic             clock_out,
  output logic             tick,
  output logic [CNT_W-1:0] active_div,
  output logic             busy,
`ifdef FREQ_DIV_CTRL_PERIOD_CNT_EN
  output logic [15:0]      period_count,
`endif
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] div_d;
  logic             busy_d;
  logic             clk_d, tick_d;
  logic             wrap, accept, running_d;
  logic [CNT_W-1:0] clamped;

  assign wrap      = (cnt_q == (active_div - CNT_W'(1)));
  assign accept    = div_valid && !busy;
  assign clamped   = (div_value < MIN_DIV) ? MIN_DIV : div_value;
  assign div_ready = !busy;
  assign state_dbg = state_q;

  // Next-state, counter, divisor and output computation; outputs are derived
  // from the next counter so the registered clock_out lines up with counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = active_div;
    busy_d    = busy;
    pend_d    = pend_q;
    running_d = 1'b0;
    clk_d     = 1'b0;
    tick_d    = 1'b0;

    // accept and apply never coincide: accept needs busy low, apply needs it high
    if (accept) begin
      pend_d = clamped;
      busy_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (busy) begin
          div_d  = pend_q;
          busy_d = 1'b0;
        end
        if (run) state_d = RUN;
      end
      RUN, STOP: begin
        if (wrap) begin
          cnt_d = '0;
          if (busy) begin
            div_d  = pend_q;
            busy_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // a stop request only takes effect once the current period has ended
        if (run)       state_d = RUN;
        else if (wrap) state_d = IDLE;
        else           state_d = STOP;
      end
      default: state_d = IDLE;
    endcase

    running_d = (state_d != IDLE);
    clk_d     = running_d && (cnt_d < (div_d >> 1));
    tick_d    = running_d && (cnt_d == '0);
  end

  // State, counter, divisor, pending update and registered outputs
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_q     <= DEF_DIV;
      active_div <= DEF_DIV;
      busy       <= 1'b0;
      clock_out  <= 1'b0;
      tick       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      active_div <= div_d;
      busy       <= busy_d;
      clock_out  <= clk_d;
      tick       <= tick_d;
    end
  end

`ifdef FREQ_DIV_CTRL_PERIOD_CNT_EN
  // Count periods; advances together with each tick, holds while idle
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n)    period_count <= 16'd0;
    else if (tick_d) period_count <= period_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_freq_div_ctrl.sv
// tb_freq_div_ctrl: vector table plus hand-written sequences for
// freq_div_ctrl. Inputs change and outputs are sampled on the falling edge.
module tb_freq_div_ctrl;

  localparam int CNT_W = 10;

  logic             clock_in;
  logic             reset_n;
  logic             run;
  logic             div_valid;
  logic [CNT_W-1:0] div_value;
  logic             div_ready;
  logic             clock_out;
  logic             tick;
  logic [CNT_W-1:0] active_div;
  logic             busy;
  logic [1:0]       state_dbg;
`ifdef FREQ_DIV_CTRL_PERIOD_CNT_EN
  logic [15:0]      period_count;
`endif

  freq_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(2)) dut (
    .clock_in     (clock_in),
    .reset_n      (reset_n),
    .run          (run),
    .div_valid    (div_valid),
    .div_value    (div_value),
    .div_ready    (div_ready),
    .clock_out    (clock_out),
    .tick         (tick),
    .active_div   (active_div),
    .busy         (busy),
`ifdef FREQ_DIV_CTRL_PERIOD_CNT_EN
    .period_count (period_count),
`endif
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // expected word: {clock_out, tick, busy, div_ready, active_div}
  typedef struct packed {
    logic             run;
    logic             vld;
    logic [CNT_W-1:0] val;
    logic [13:0]      e;
  } vec_t;

  vec_t        vecs[16];
  logic [13:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          step_no = 0;
  string       section = "";

  // expected outputs while running at counter cnt with divisor d
  function automatic logic [13:0] ex(input int cnt, input int d, input logic b);
    logic c;
    logic t;
    c = (cnt < d / 2);
    t = (cnt == 0);
    return {c, t, b, ~b, CNT_W'(d)};
  endfunction

  // expected outputs while idle
  function automatic logic [13:0] ex_idle(input int d, input logic b);
    return {1'b0, 1'b0, b, ~b, CNT_W'(d)};
  endfunction

  task automatic compare(input logic [13:0] e, input string tag);
    logic [13:0] act;
    act = {clock_out, tick, busy, div_ready, active_div};
    n_vec++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s step %0d: got clk=%b tick=%b busy=%b rdy=%b div=%0d, required clk=%b tick=%b busy=%b rdy=%b div=%0d",
               tag, step_no, act[13], act[12], act[11], act[10], act[9:0],
               e[13], e[12], e[11], e[10], e[9:0]);
    end
  endtask

  // driver: apply one cycle of inputs, queue the expectation, check after the edge
  task automatic step(input logic r, input logic v, input logic [CNT_W-1:0] val,
                      input logic [13:0] e);
    run       = r;
    div_valid = v;
    div_value = val;
    exp_q.push_back(e);
    @(negedge clock_in);
    step_no++;
    compare(exp_q.pop_front(), section);
  endtask

  initial begin
    // D=2 free-run, then a request of 5 landing on a wrap edge
    vecs[0]  = '{run:1'b1, vld:1'b0, val:'0,         e:ex(0, 2, 1'b0)};
    vecs[1]  = '{run:1'b1, vld:1'b0, val:'0,         e:ex(1, 2, 1'b0)};
    vecs[2]  = '{run:1'b1, vld:1'b0, val:'0,         e:ex(0, 2, 1'b0)};
    vecs[3]  = '{run:1'b1, vld:1'b0, val:'0,         e:ex(1, 2, 1'b0)};
    vecs[4]  = '{run:1'b1, vld:1'b1, val:CNT_W'(5),  e:ex(0, 2, 1'b1)};
    vecs[5]  = '{run:1'b1, vld:1'b0, val:'0,         e:ex(1, 2, 1'b1)};
    vecs[6]  = '{run:1'b1, vld:1'b0, val:'0,         e:ex(0, 5, 1'b0)};
    vecs[7]  = '{run:1'b1, vld:1'b0, val:'0,         e:ex(1, 5, 1'b0)};
    vecs[8]  = '{run:1'b1, vld:1'b0, val:'0,         e:ex(2, 5, 1'b0)};
    vecs[9]  = '{run:1'b1, vld:1'b0, val:'0,         e:ex(3, 5, 1'b0)};
    vecs[10] = '{run:1'b1, vld:1'b0, val:'0,         e:ex(4, 5, 1'b0)};
    vecs[11] = '{run:1'b1, vld:1'b0, val:'0,         e:ex(0, 5, 1'b0)};
    vecs[12] = '{run:1'b1, vld:1'b0, val:'0,         e:ex(1, 5, 1'b0)};
    vecs[13] = '{run:1'b1, vld:1'b0, val:'0,         e:ex(2, 5, 1'b0)};
    vecs[14] = '{run:1'b1, vld:1'b0, val:'0,         e:ex(3, 5, 1'b0)};
    vecs[15] = '{run:1'b1, vld:1'b0, val:'0,         e:ex(4, 5, 1'b0)};

    reset_n   = 1'b0;
    run       = 1'b0;
    div_valid = 1'b0;
    div_value = '0;
    repeat (3) @(negedge clock_in);
    section = "reset";
    compare(ex_idle(2, 1'b0), section);
    reset_n = 1'b1;

    section = "table";
    for (int i = 0; i < 16; i++) step(vecs[i].run, vecs[i].vld, vecs[i].val, vecs[i].e);

    // D=6 requested at a wrap, then stop dropped at counter 1
    section = "stop_drain";
    step(1, 1, 6, ex(0, 5, 1'b1));
    for (int c = 1; c <= 4; c++) step(1, 0, 0, ex(c, 5, 1'b1));
    step(1, 0, 0, ex(0, 6, 1'b0));
    step(1, 0, 0, ex(1, 6, 1'b0));
    for (int c = 2; c <= 5; c++) step(0, 0, 0, ex(c, 6, 1'b0));
    step(0, 0, 0, ex_idle(6, 1'b0));
    step(0, 0, 0, ex_idle(6, 1'b0));
    n_vec++;
    if (state_dbg !== 2'd0) begin
      n_err++;
      $display("FAIL idle_state: got state=%0d, required 0", state_dbg);
    end

    // stop then reassert before the boundary: cadence uninterrupted
    section = "stop_resume";
    step(1, 0, 0, ex(0, 6, 1'b0));
    step(1, 0, 0, ex(1, 6, 1'b0));
    step(0, 0, 0, ex(2, 6, 1'b0));
    step(0, 0, 0, ex(3, 6, 1'b0));
    step(1, 0, 0, ex(4, 6, 1'b0));
    step(1, 0, 0, ex(5, 6, 1'b0));
    step(1, 0, 0, ex(0, 6, 1'b0));
    for (int c = 1; c <= 5; c++) step(1, 0, 0, ex(c, 6, 1'b0));
    step(1, 0, 0, ex(0, 6, 1'b0));
    for (int c = 1; c <= 5; c++) step(0, 0, 0, ex(c, 6, 1'b0));
    step(0, 0, 0, ex_idle(6, 1'b0));

    // illegal divisors in IDLE clamp to 2
    section = "clamp";
    step(0, 1, 0, ex_idle(6, 1'b1));
    step(0, 0, 0, ex_idle(2, 1'b0));
    step(0, 1, 1, ex_idle(2, 1'b1));
    step(0, 0, 0, ex_idle(2, 1'b0));

    // second request held while busy, accepted after the first applies
    section = "back_to_back";
    step(1, 0, 0, ex(0, 2, 1'b0));
    step(1, 1, 4, ex(1, 2, 1'b1));
    step(1, 1, 8, ex(0, 4, 1'b0));
    step(1, 1, 8, ex(1, 4, 1'b1));
    step(1, 0, 0, ex(2, 4, 1'b1));
    step(1, 0, 0, ex(3, 4, 1'b1));
    step(1, 0, 0, ex(0, 8, 1'b0));
    for (int c = 1; c <= 3; c++) step(1, 0, 0, ex(c, 8, 1'b0));

    // async reset mid-period with an update pending
    section = "mid_reset";
    step(1, 1, 3, ex(4, 8, 1'b1));
    #2 reset_n = 1'b0;
    #1 compare(ex_idle(2, 1'b0), "async_reset");
    @(negedge clock_in);
    reset_n = 1'b1;
    step(1, 0, 0, ex(0, 2, 1'b0));
    step(1, 0, 0, ex(1, 2, 1'b0));
    step(1, 0, 0, ex(0, 2, 1'b0));

    // update pending at the final wrap of a stop: applied, then idle
    section = "stop_apply";
    step(0, 1, 3, ex(1, 2, 1'b1));
    step(0, 0, 0, ex_idle(3, 1'b0));
    step(0, 0, 0, ex_idle(3, 1'b0));

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
